// File: rtl/hamming_search_64_if.sv
// Interface: hamming_search_64_if
// Groups the class-memory write port, the chunk input handshake and the result
// output handshake of hamming_search_64.
//   class_we/class_sel/class_addr/class_wdata : class memory write port
//   in_valid/in_ready/in_data                 : encoded chunk input
//   out_valid/out_ready/out_class/out_dist    : nearest-class result
//   busy                                      : frame being drained/searched/held
// Modports: master drives requests (testbench / upstream), slave is the search block.
interface hamming_search_64_if #(
  parameter int M_SIZE      = 64,
  parameter int VAL_WIDTH   = 8,
  parameter int NUM_CHUNKS  = 8,
  parameter int NUM_CLASSES = 4
);
  localparam int CLS_W  = $clog2(NUM_CLASSES);
  localparam int CHK_W  = $clog2(NUM_CHUNKS);
  localparam int DIST_W = $clog2(M_SIZE * NUM_CHUNKS + 1);

  logic                               class_we;
  logic [CLS_W-1:0]                   class_sel;
  logic [CHK_W-1:0]                   class_addr;
  logic [M_SIZE-1:0]                  class_wdata;
  logic                               in_valid;
  logic                               in_ready;
  logic [M_SIZE-1:0][VAL_WIDTH-1:0]   in_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [CLS_W-1:0]                   out_class;
  logic [DIST_W-1:0]                  out_dist;
  logic                               busy;

  modport master (
    output class_we, class_sel, class_addr, class_wdata,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_dist, busy
  );

  modport slave (
    input  class_we, class_sel, class_addr, class_wdata,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_dist, busy
  );
endinterface

// File: rtl/hamming_search_64.sv
// Module: hamming_search_64
// Binarizes each encoded chunk by sign, accumulates the Hamming distance to every
// stored class hypervector over NUM_CHUNKS chunks, then runs a sequential argmin
// and presents the nearest class and its distance.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : hamming_search_64_if.slave (class write port, chunk input, result output)
//
// state  | meaning
// ACCUM  | accepting chunks, stage 2 adds popcounts
// DRAIN  | last chunk's popcount being added
// SEARCH | argmin, one class per cycle
// RESULT | result held until out_ready
module hamming_search_64 #(
  parameter int M_SIZE      = 64,
  parameter int VAL_WIDTH   = 8,
  parameter int NUM_CHUNKS  = 8,
  parameter int NUM_CLASSES = 4
) (
  input logic              clk,
  input logic              reset,
  hamming_search_64_if.slave bus
);
  localparam int CLS_W  = $clog2(NUM_CLASSES);
  localparam int CHK_W  = $clog2(NUM_CHUNKS);
  localparam int DIST_W = $clog2(M_SIZE * NUM_CHUNKS + 1);
  localparam int POP_W  = $clog2(M_SIZE + 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, SEARCH, RESULT} state_t;

  state_t              state_q, state_d;
  logic [CHK_W-1:0]    chk_cnt_q, chk_cnt_d;
  logic                s1_valid_q, s1_valid_d;
  logic [M_SIZE-1:0]   s1_bits_q, s1_bits_d;
  logic [CHK_W-1:0]    s1_idx_q, s1_idx_d;
  logic [DIST_W-1:0]   acc_q [NUM_CLASSES];
  logic [DIST_W-1:0]   acc_d [NUM_CLASSES];
  logic [CLS_W-1:0]    search_k_q, search_k_d;
  logic                out_valid_q, out_valid_d;
  logic [CLS_W-1:0]    out_class_q, out_class_d;
  logic [DIST_W-1:0]   out_dist_q, out_dist_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [M_SIZE-1:0]   mem_q [NUM_CLASSES][NUM_CHUNKS];
  logic [M_SIZE-1:0]   mem_d [NUM_CLASSES][NUM_CHUNKS];
  logic [M_SIZE-1:0]   bin;
  logic                accept;

  function automatic logic [POP_W-1:0] popcount(input logic [M_SIZE-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < M_SIZE; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < M_SIZE; i++) bin[i] = ~bus.in_data[i][VAL_WIDTH-1];
    accept = bus.in_valid & in_ready_q & (state_q == ACCUM);

    state_d     = state_q;
    chk_cnt_d   = chk_cnt_q;
    s1_valid_d  = accept;
    s1_bits_d   = accept ? bin : s1_bits_q;
    s1_idx_d    = accept ? chk_cnt_q : s1_idx_q;
    acc_d       = acc_q;
    search_k_d  = search_k_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_dist_d  = out_dist_q;
    mem_d       = mem_q;

    // Writes during reset are ignored; the memory itself keeps its contents.
    if (!reset && bus.class_we && int'(bus.class_sel) < NUM_CLASSES)
      mem_d[bus.class_sel][bus.class_addr] = bus.class_wdata;

    // Stage 2 reads mem_q, so a same-edge write to the same word is seen next frame.
    if (s1_valid_q)
      for (int k = 0; k < NUM_CLASSES; k++)
        acc_d[k] = acc_q[k] + DIST_W'(popcount(s1_bits_q ^ mem_q[k][s1_idx_q]));

    case (state_q)
      ACCUM: begin
        if (accept) begin
          chk_cnt_d = chk_cnt_q + 1'b1;
          if (chk_cnt_q == CHK_W'(NUM_CHUNKS - 1)) begin
            chk_cnt_d = '0;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d    = SEARCH;
        search_k_d = '0;
      end
      SEARCH: begin
        // out_dist/out_class double as the running best; strict < keeps the lower index on ties.
        if (search_k_q == '0) begin
          out_dist_d  = acc_q[0];
          out_class_d = '0;
        end else if (acc_q[search_k_q] < out_dist_q) begin
          out_dist_d  = acc_q[search_k_q];
          out_class_d = search_k_q;
        end
        if (search_k_q == CLS_W'(NUM_CLASSES - 1)) begin
          state_d     = RESULT;
          out_valid_d = 1'b1;
        end else begin
          search_k_d = search_k_q + 1'b1;
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
          chk_cnt_d   = '0;
          for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = '0;
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != ACCUM);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q     <= ACCUM;
      chk_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_bits_q   <= '0;
      s1_idx_q    <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= '0;
      search_k_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_dist_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_cnt_q   <= chk_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_bits_q   <= s1_bits_d;
      s1_idx_q    <= s1_idx_d;
      acc_q       <= acc_d;
      search_k_q  <= search_k_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_dist_q  <= out_dist_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_dist  = out_dist_q;
endmodule

// File: tb/tb_hamming_search_64.sv
module tb_hamming_search_64;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hamming_search_64_if bus ();
  hamming_search_64 dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int         set;
    logic [7:0] val;
    int         ecls;
    int         edist;
  } vec_t;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALT  = 64'h5555_5555_5555_5555;

  logic [63:0] cls [4][8];
  logic [7:0]  frame [8][64];
  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_class(input int k, input int c, input logic [63:0] d);
    bus.class_we    = 1'b1;
    bus.class_sel   = 2'(k);
    bus.class_addr  = 3'(c);
    bus.class_wdata = d;
    @(posedge clk); #1;
    bus.class_we = 1'b0;
    cls[k][c] = d;
  endtask

  task automatic load_set(input int s);
    for (int c = 0; c < 8; c++) begin
      if (s == 0) begin
        load_class(0, c, ALL1);
        load_class(1, c, 64'h0);
        load_class(2, c, ALT);
        load_class(3, c, (c == 0) ? 64'h0 : ALL1);
      end else begin
        load_class(0, c, ALT);
        load_class(1, c, ALL1);
        load_class(2, c, ALT);
        load_class(3, c, ALL1);
      end
    end
  endtask

  task automatic fill_frame(input logic [7:0] v);
    for (int c = 0; c < 8; c++)
      for (int e = 0; e < 64; e++) frame[c][e] = v;
  endtask

  task automatic send_chunks(input int n, input int max_gap, output int accepted);
    bit rdy;
    int waited;
    accepted = 0;
    for (int c = 0; c < n; c++) begin
      repeat ((max_gap > 0) ? $urandom_range(max_gap, 0) : 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      for (int e = 0; e < 64; e++) bus.in_data[e] = frame[c][e];
      waited = 0;
      do begin
        rdy = bus.in_ready;
        @(posedge clk); #1;
        waited++;
      end while (!rdy && waited < 100);
      if (!rdy) break;
      accepted++;
    end
    bus.in_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the last chunk.
  task automatic wait_result(input string tag);
    int n;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_in_ready_drain"}, bus.in_ready, 0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 5);
  endtask

  task automatic take_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, bus.out_valid, 0);
    check({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int ecls, input int edist);
    int acc_n;
    send_chunks(8, max_gap, acc_n);
    check({tag, "_accepted"}, acc_n, 8);
    wait_result(tag);
    check({tag, "_class"}, bus.out_class, ecls);
    check({tag, "_dist"}, bus.out_dist, edist);
    take_result(tag);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_out_class"}, bus.out_class, 0);
    check({tag, "_out_dist"}, bus.out_dist, 0);
  endtask

  function automatic void ref_model(output int bc, output int bd);
    int d [4];
    for (int k = 0; k < 4; k++) begin
      d[k] = 0;
      for (int c = 0; c < 8; c++)
        for (int e = 0; e < 64; e++)
          if ((~frame[c][e][7]) != cls[k][c][e]) d[k]++;
    end
    bc = 0;
    bd = d[0];
    for (int k = 1; k < 4; k++)
      if (d[k] < bd) begin
        bd = d[k];
        bc = k;
      end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_set, n, mc, md;
    logic [1:0] hold_cls;
    logic [9:0] hold_dist;

    vecs[0] = '{0, 8'h01, 0, 0};
    vecs[1] = '{0, 8'hFF, 1, 0};
    vecs[2] = '{0, 8'h00, 0, 0};
    vecs[3] = '{0, 8'h80, 1, 0};
    vecs[4] = '{0, 8'h7F, 0, 0};
    vecs[5] = '{1, 8'hFF, 0, 256};
    vecs[6] = '{1, 8'h01, 1, 0};
    vecs[7] = '{0, 8'hC3, 1, 0};

    reset = 1'b1;
    bus.class_we = 1'b0;
    bus.class_sel = '0;
    bus.class_addr = '0;
    bus.class_wdata = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    cur_set = -1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].set != cur_set) begin
        load_set(vecs[i].set);
        cur_set = vecs[i].set;
      end
      fill_frame(vecs[i].val);
      run_frame($sformatf("vec%0d", i), 0, vecs[i].ecls, vecs[i].edist);
    end

    // Backpressure: result held, no chunk accepted while out_ready is low.
    fill_frame(8'h01);
    send_chunks(8, 0, n);
    check("bp_accepted", n, 8);
    wait_result("bp");
    hold_cls = bus.out_class;
    hold_dist = bus.out_dist;
    check("bp_class", hold_cls, 0);
    check("bp_dist", hold_dist, 0);
    bus.in_valid = 1'b1;
    for (int e = 0; e < 64; e++) bus.in_data[e] = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_in_ready", bus.in_ready, 0);
      check("bp_hold_class", bus.out_class, 0);
      check("bp_hold_dist", bus.out_dist, 0);
    end
    bus.in_valid = 1'b0;
    take_result("bp");
    fill_frame(8'hFF);
    run_frame("bp_second", 0, 1, 0);

    // Reset mid-frame: three 8'hFF chunks then reset with in_valid held high.
    fill_frame(8'hFF);
    send_chunks(3, 0, n);
    check("abort_accepted", n, 3);
    bus.in_valid = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("abort");
    fill_frame(8'h01);
    run_frame("after_abort", 0, 0, 0);

    // Random classes, random data, random idle gaps.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 8; c++) load_class(k, c, {$urandom, $urandom});
      for (int c = 0; c < 8; c++)
        for (int e = 0; e < 64; e++) frame[c][e] = 8'($urandom);
      ref_model(mc, md);
      run_frame($sformatf("rand%0d", f), 3, mc, md);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
